red_pitaya_ams_mon: RTL and testbench

Parametrised slow-ADC monitor that sits between the XADC DRP read-back stream and the system bus in the analog mixed-signal section. It demultiplexes sequencer samples into NCH user channels and block-averages each channel over 2^AVG_LOG2 samples. It raises sticky per-channel over-threshold alarms and exposes raw, averaged and status registers to SW. It generalises the fixed 4-channel latch-and-strobe scheme with configurable channel count, channel map, averaging depth and alarming.

---
 rtl/red_pitaya_ams_mon.sv | 173 +++++++++++++++++
 tb/tb_red_pitaya_ams_mon.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_ams_mon.sv
// red_pitaya_ams_mon: demuxes XADC sequencer samples into user channels, block-averages them,
// raises sticky threshold alarms and exposes it all on the system bus. RED_PITAYA_AMS_MINMAX_EN adds min/max.
module red_pitaya_ams_mon #(
    parameter int NCH      = 4,
    parameter int DW       = 12,
    parameter int CH_AW    = 5,
    parameter int AVG_LOG2 = 2,
    parameter logic [NCH*CH_AW-1:0] CH_MAP = {5'd25, 5'd17, 5'd16, 5'd24}
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              smp_vld_i,
    input  logic [CH_AW-1:0]  smp_ch_i,
    input  logic [DW-1:0]     smp_dat_i,
    output logic [NCH*DW-1:0] avg_o,
    output logic [NCH-1:0]    strobe_o,
    output logic [NCH-1:0]    alarm_o,
    input  logic [31:0]       sys_addr_i,
    input  logic [31:0]       sys_wdata_i,
    input  logic [3:0]        sys_sel_i,
    input  logic              sys_wen_i,
    input  logic              sys_ren_i,
    output logic [31:0]       sys_rdata_o,
    output logic              sys_err_o,
    output logic              sys_ack_o
);
    localparam int AW = DW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic                    en_q;
    logic [NCH-1:0][DW-1:0]  last_q, avg_q, thr_q;
    logic [NCH-1:0][AW-1:0]  acc_q;
    logic [NCH-1:0][CW-1:0]  cnt_q;
    logic [NCH-1:0]          alarm_q, strobe_q;
    logic [31:0]             smp_cnt_q;
    logic                    ack_q;
    logic [31:0]             rdata_q, rdata_d;

    logic [19:0]             addr;
    logic [5:0]              idx;
    logic                    wr_ctrl, wr_alarm, wr_thr, clr;
    logic [NCH-1:0]          hit, blk_end, alarm_set, w1c;
    logic [NCH-1:0][AW-1:0]  sum;
    logic [NCH-1:0][DW-1:0]  avg_new;
    logic [DW-1:0]           sel_last, sel_avg, sel_thr, sel_min, sel_max;
    logic                    unused;

    assign addr     = sys_addr_i[19:0];
    assign idx      = sys_addr_i[7:2];
    assign wr_ctrl  = sys_wen_i && (addr == 20'h0);
    assign wr_alarm = sys_wen_i && (addr == 20'h4);
    assign wr_thr   = sys_wen_i && (addr[19:8] == 12'h003);
    assign clr      = wr_ctrl && sys_wdata_i[1];
    assign w1c      = wr_alarm ? sys_wdata_i[NCH-1:0] : '0;
    assign unused   = ^{sys_sel_i, sys_addr_i, sys_wdata_i};

    // A clear in the same cycle as a sample discards the sample entirely.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hit[k]       = smp_vld_i && en_q && !clr && (smp_ch_i == CH_MAP[k*CH_AW +: CH_AW]);
            sum[k]       = acc_q[k] + AW'(smp_dat_i);
            avg_new[k]   = DW'(sum[k] >> AVG_LOG2);
            blk_end[k]   = hit[k] && (cnt_q[k] == CNT_LAST);
            alarm_set[k] = blk_end[k] && (avg_new[k] > thr_q[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q      <= 1'b1;
            last_q    <= '0;
            avg_q     <= '0;
            thr_q     <= '1;
            acc_q     <= '0;
            cnt_q     <= '0;
            alarm_q   <= '0;
            strobe_q  <= '0;
            smp_cnt_q <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            strobe_q <= blk_end;
            alarm_q  <= (alarm_q & ~w1c) | alarm_set;
            ack_q    <= sys_wen_i | sys_ren_i;
            rdata_q  <= sys_ren_i ? rdata_d : '0;
            if (wr_ctrl) en_q <= sys_wdata_i[0];
            if (|hit) smp_cnt_q <= smp_cnt_q + 32'd1;
            for (int k = 0; k < NCH; k++) begin
                if (wr_thr && (idx == 6'(k))) thr_q[k] <= sys_wdata_i[DW-1:0];
                if (clr) begin
                    acc_q[k] <= '0;
                    cnt_q[k] <= '0;
                end else if (hit[k]) begin
                    last_q[k] <= smp_dat_i;
                    if (blk_end[k]) begin
                        avg_q[k] <= avg_new[k];
                        acc_q[k] <= '0;
                        cnt_q[k] <= '0;
                    end else begin
                        acc_q[k] <= sum[k];
                        cnt_q[k] <= cnt_q[k] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef RED_PITAYA_AMS_MINMAX_EN
    logic [NCH-1:0][DW-1:0] min_q, max_q;
    logic                   mmclr;

    assign mmclr = wr_ctrl && sys_wdata_i[2];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            min_q <= '1;
            max_q <= '0;
        end else if (mmclr) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (hit[k] && (smp_dat_i < min_q[k])) min_q[k] <= smp_dat_i;
                if (hit[k] && (smp_dat_i > max_q[k])) max_q[k] <= smp_dat_i;
            end
        end
    end
`endif

    always_comb begin
        sel_last = '0;
        sel_avg  = '0;
        sel_thr  = '0;
        sel_min  = '0;
        sel_max  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == 6'(k)) begin
                sel_last = last_q[k];
                sel_avg  = avg_q[k];
                sel_thr  = thr_q[k];
`ifdef RED_PITAYA_AMS_MINMAX_EN
                sel_min  = min_q[k];
                sel_max  = max_q[k];
`endif
            end
        end
        rdata_d = '0;
        case (addr[19:8])
            12'h000: begin
                case (addr[7:0])
                    8'h00:   rdata_d = {31'b0, en_q};
                    8'h04:   rdata_d = 32'(alarm_q);
                    8'h08:   rdata_d = smp_cnt_q;
                    default: rdata_d = '0;
                endcase
            end
            12'h001: rdata_d = 32'(sel_last);
            12'h002: rdata_d = 32'(sel_avg);
            12'h003: rdata_d = 32'(sel_thr);
            12'h004: rdata_d = 32'(sel_min);
            12'h005: rdata_d = 32'(sel_max);
            default: rdata_d = '0;
        endcase
    end

    assign avg_o       = avg_q;
    assign strobe_o    = strobe_q;
    assign alarm_o     = alarm_q;
    assign sys_rdata_o = rdata_q;
    assign sys_ack_o   = ack_q;
    assign sys_err_o   = 1'b0;
endmodule

// File: tb/tb_red_pitaya_ams_mon.sv
// Bench for red_pitaya_ams_mon: directed test-plan scenarios plus random traffic against a block-sum model.
`timescale 1ns/1ps
module tb_red_pitaya_ams_mon;
    localparam int NCH = 4, DW = 12, CH_AW = 5, AVG_LOG2 = 2, BL = 4;
    localparam logic [19:0] MAP = {5'd25, 5'd17, 5'd16, 5'd24};

    logic              clk = 1'b0, rstn = 1'b0;
    logic              smp_vld = 1'b0;
    logic [CH_AW-1:0]  smp_ch = '0;
    logic [DW-1:0]     smp_dat = '0;
    logic [NCH*DW-1:0] avg;
    logic [NCH-1:0]    strobe, alarm;
    logic [31:0]       addr = '0, wdata = '0, rdata;
    logic [3:0]        sel = 4'hF;
    logic              wen = 1'b0, ren = 1'b0, err, ack;

    always #5 clk = ~clk;

    red_pitaya_ams_mon #(.NCH(NCH), .DW(DW), .CH_AW(CH_AW), .AVG_LOG2(AVG_LOG2), .CH_MAP(MAP)) dut (
        .clk_i(clk), .rstn_i(rstn), .smp_vld_i(smp_vld), .smp_ch_i(smp_ch), .smp_dat_i(smp_dat),
        .avg_o(avg), .strobe_o(strobe), .alarm_o(alarm),
        .sys_addr_i(addr), .sys_wdata_i(wdata), .sys_sel_i(sel), .sys_wen_i(wen), .sys_ren_i(ren),
        .sys_rdata_o(rdata), .sys_err_o(err), .sys_ack_o(ack)
    );

    int n_chk = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: running block sum and sample count per channel
    int unsigned map_id[NCH];
    int unsigned m_thr[NCH], m_last[NCH], m_avg[NCH], m_sum[NCH], m_n[NCH], m_min[NCH], m_max[NCH];
    int unsigned m_cnt, m_rdata;
    bit [NCH-1:0] m_alarm, m_strobe;
    bit m_en, m_ack;

    task automatic model_reset();
        m_en = 1; m_cnt = 0; m_rdata = 0; m_ack = 0; m_alarm = '0; m_strobe = '0;
        for (int k = 0; k < NCH; k++) begin
            m_thr[k] = 'hFFF; m_last[k] = 0; m_avg[k] = 0; m_sum[k] = 0; m_n[k] = 0;
            m_min[k] = 'hFFF; m_max[k] = 0;
        end
    endtask

    function automatic int unsigned m_read(input int unsigned a_in);
        int unsigned a = a_in & 32'hFFFFF;
        int unsigned region = a >> 8;
        int unsigned k = (a >> 2) & 63;
        if (region == 0) begin
            if (a == 0) return m_en;
            if (a == 4) return m_alarm;
            if (a == 8) return m_cnt;
            return 0;
        end
        if (k >= NCH) return 0;
        case (region)
            1: return m_last[k];
            2: return m_avg[k];
            3: return m_thr[k];
`ifdef RED_PITAYA_AMS_MINMAX_EN
            4: return m_min[k];
            5: return m_max[k];
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit vld, input int unsigned ch, input int unsigned dat,
                              input bit w, input bit r, input int unsigned a, input int unsigned wd);
        int unsigned am = a & 32'hFFFFF;
        bit clr = w && (am == 0) && wd[1];
        bit mm  = w && (am == 0) && wd[2];
        bit any = 0;
        bit [NCH-1:0] setb = '0;
        m_rdata = r ? m_read(a) : 0;
        m_ack = w | r;
        m_strobe = '0;
        if (vld && m_en && !clr) begin
            for (int k = 0; k < NCH; k++) begin
                if (ch == map_id[k]) begin
                    any = 1;
                    m_last[k] = dat;
                    m_sum[k] += dat;
                    m_n[k]++;
                    if (!mm && dat < m_min[k]) m_min[k] = dat;
                    if (!mm && dat > m_max[k]) m_max[k] = dat;
                    if (m_n[k] == BL) begin
                        m_avg[k] = m_sum[k] / BL;
                        m_sum[k] = 0; m_n[k] = 0;
                        m_strobe[k] = 1;
                        if (m_avg[k] > m_thr[k]) setb[k] = 1;
                    end
                end
            end
            if (any) m_cnt++;
        end
        for (int k = 0; k < NCH; k++) begin
            if (clr) begin m_sum[k] = 0; m_n[k] = 0; end
            if (mm) begin m_min[k] = 'hFFF; m_max[k] = 0; end
        end
        if (w) begin
            if (am == 0) m_en = wd[0];
            if (am == 4) m_alarm &= ~wd[NCH-1:0];
            if ((am >> 8) == 3 && ((am >> 2) & 63) < NCH) m_thr[(am >> 2) & 63] = wd & 'hFFF;
        end
        m_alarm |= setb;
    endtask

    task automatic cyc(input bit vld, input int unsigned ch, input int unsigned dat,
                       input bit w, input bit r, input int unsigned a, input int unsigned wd);
        smp_vld = vld; smp_ch = ch[CH_AW-1:0]; smp_dat = dat[DW-1:0];
        wen = w; ren = r; addr = a; wdata = wd;
        @(posedge clk);
        model_step(vld, ch & 31, dat & 'hFFF, w, r, a, wd);
        #1;
        check("strobe", 32'(strobe), 32'(m_strobe));
        check("alarm", 32'(alarm), 32'(m_alarm));
        check("ack", 32'(ack), 32'(m_ack));
        check("rdata", rdata, m_rdata);
        check("err", 32'(err), 32'd0);
        for (int k = 0; k < NCH; k++) check("avg_o", 32'(avg[k*DW +: DW]), m_avg[k]);
        smp_vld = 0; wen = 0; ren = 0;
    endtask

    task automatic smp(input int unsigned ch, input int unsigned dat);
        cyc(1, ch, dat, 0, 0, 0, 0);
    endtask

    task automatic wr(input int unsigned a, input int unsigned d);
        cyc(0, 0, 0, 1, 0, a, d);
    endtask

    task automatic rd(input int unsigned a, output logic [31:0] d);
        cyc(0, 0, 0, 0, 1, a, 0);
        d = rdata;
    endtask

    task automatic do_reset();
        #2 rstn = 0;
        #1;
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_avg", 32'(|avg), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
    endtask

    logic [31:0] d;
    logic [19:0] map_v;

    initial begin
        map_v = MAP;
        for (int k = 0; k < NCH; k++) map_id[k] = map_v[k*CH_AW +: CH_AW];
        model_reset();
        do_reset();
        rd(32'h0, d);   check("ctrl_rst", d, 32'h1);
        rd(32'h300, d); check("thr0_rst", d, 32'hFFF);

        smp(24, 100); smp(24, 200); smp(24, 300); smp(24, 400);
        check("strobe_pulse", 32'(strobe), 32'h1);
        smp(3, 0);
        check("strobe_drop", 32'(strobe), 32'h0);
        rd(32'h200, d); check("avg0", d, 250);
        rd(32'h100, d); check("last0", d, 400);
        rd(32'h8, d);   check("count4", d, 4);

        wr(32'h304, 32'h800);
        repeat (4) smp(16, 32'h900);
        check("alarm1", 32'(alarm), 32'h2);
        rd(32'h4, d); check("alarm_rd", d, 32'h2);
        wr(32'h4, 32'h2);
        check("alarm_clr", 32'(alarm), 32'h0);
        repeat (3) smp(16, 32'h900);
        cyc(1, 16, 32'h900, 1, 0, 32'h4, 32'h2);
        check("alarm_setwins", 32'(alarm), 32'h2);

        smp(3, 50); smp(3, 60);
        wr(32'h0, 32'h0);
        smp(24, 999); smp(24, 999);
        wr(32'h0, 32'h1);
        rd(32'h8, d);   check("count_filt", d, 12);
        rd(32'h100, d); check("last0_filt", d, 400);

        smp(24, 1000); smp(24, 1000);
        cyc(1, 24, 1000, 1, 0, 32'h0, 32'h3);
        repeat (4) smp(24, 8);
        rd(32'h200, d); check("avg0_clr", d, 8);

        smp(17, 5); smp(17, 4000); smp(17, 7);
        rd(32'h408, d);
`ifdef RED_PITAYA_AMS_MINMAX_EN
        check("min2", d, 5);
`else
        check("min2", d, 0);
`endif
        rd(32'h508, d);
`ifdef RED_PITAYA_AMS_MINMAX_EN
        check("max2", d, 4000);
`else
        check("max2", d, 0);
`endif
        wr(32'h0, 32'h5);
        rd(32'h408, d);
`ifdef RED_PITAYA_AMS_MINMAX_EN
        check("min2_mmclr", d, 32'hFFF);
`else
        check("min2_mmclr", d, 0);
`endif
        rd(32'h508, d); check("max2_mmclr", d, 0);

        for (int i = 0; i < 3000; i++) begin
            int unsigned r, ch, a, wd, base;
            if (i == 1500) do_reset();
            r = $urandom_range(0, 5);
            ch = (r < NCH) ? map_id[r] : (r == 4 ? 3 : $urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0: base = 0;
                1: base = 4;
                2: base = 8;
                3: base = 32'h100 | ($urandom_range(0, 7) << 2);
                4: base = 32'h200 | ($urandom_range(0, 7) << 2);
                5, 6: base = 32'h300 | ($urandom_range(0, 7) << 2);
                7: base = 32'h400 | ($urandom_range(0, 7) << 2);
                8: base = 32'h500 | ($urandom_range(0, 7) << 2);
                default: base = $urandom_range(0, 32'hFFFFF);
            endcase
            a = ($urandom & 32'hFFF00000) | base;
            wd = $urandom;
            if ((a & 32'hFFFFF) == 0) begin
                wd[0] = ($urandom_range(0, 7) != 0);
                wd[1] = ($urandom_range(0, 5) == 0);
                wd[2] = ($urandom_range(0, 5) == 0);
            end
            cyc($urandom_range(0, 3) != 0, ch, $urandom_range(0, 4095),
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, a, wd);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
